// File: rtl/parallel_adder_stream_ctrl.sv
// rtl/parallel_adder_stream_ctrl.sv - operand loader and bit-serial sequencer for a multi-operand adder
// Optional WAIT watchdog enabled by defining PAC_TIMEOUT_EN.
module parallel_adder_stream_ctrl #(
  parameter int M       = 32,
  parameter int N       = 32,
  parameter int RW      = 37,
  parameter int TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          adder_clr,
  output logic [M-1:0]  adder_bits,
  input  logic [RW-1:0] adder_result,
  input  logic          adder_rdy,
  output logic          sum_valid,
  input  logic          sum_ready,
  output logic [RW-1:0] sum_data,
  output logic          busy,
  output logic          err
);

  localparam int WCW = (M > 1) ? $clog2(M) : 1;
  localparam int BCW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WCW-1:0] WORD_LAST = WCW'(M - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(N - 1);

  if (RW != N + $clog2(M)) begin : g_bad_rw
    $error("parallel_adder_stream_ctrl: RW must equal N + clog2(M)");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("parallel_adder_stream_ctrl: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_LOAD,
    S_CLEAR,
    S_STREAM,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          state_q;
  logic [WCW-1:0]  word_cnt_q;
  logic [BCW-1:0]  bit_cnt_q;
  logic [N-1:0]    opnd_q [M];
  logic            in_ready_q;
  logic            adder_clr_q;
  logic [M-1:0]    adder_bits_q;
  logic            sum_valid_q;
  logic [RW-1:0]   sum_data_q;
  logic            busy_q;

  logic [N-1:0]    opnd_sh_d [M];
  logic [M-1:0]    slice_d;

  // Operand k drives slice bit M-1-k, so operand 0 lands on the MSB.
  always_comb begin
    slice_d = '0;
    for (int k = 0; k < M; k++) begin
      slice_d[M-1-k] = opnd_q[k][0];
      opnd_sh_d[k]   = opnd_q[k] >> 1;
    end
  end

`ifdef PAC_TIMEOUT_EN
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCW-1:0] WAIT_LAST = TCW'(TIMEOUT - 1);
  logic [TCW-1:0] wait_cnt_q;
  logic           err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      word_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      for (int k = 0; k < M; k++) opnd_q[k] <= '0;
      in_ready_q   <= 1'b0;
      adder_clr_q  <= 1'b0;
      adder_bits_q <= '0;
      sum_valid_q  <= 1'b0;
      sum_data_q   <= '0;
      busy_q       <= 1'b0;
`ifdef PAC_TIMEOUT_EN
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_LOAD: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            opnd_q[word_cnt_q] <= in_data;
            if (word_cnt_q == WORD_LAST) begin
              word_cnt_q  <= '0;
              in_ready_q  <= 1'b0;
              adder_clr_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= S_CLEAR;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        S_CLEAR: begin
          adder_clr_q  <= 1'b0;
          adder_bits_q <= slice_d;
          for (int k = 0; k < M; k++) opnd_q[k] <= opnd_sh_d[k];
          bit_cnt_q    <= '0;
          state_q      <= S_STREAM;
        end
        S_STREAM: begin
          // N shifts in total leave the operand buffer cleared for the next load.
          if (bit_cnt_q == BIT_LAST) begin
            adder_bits_q <= '0;
            state_q      <= S_WAIT;
`ifdef PAC_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
          end else begin
            adder_bits_q <= slice_d;
            for (int k = 0; k < M; k++) opnd_q[k] <= opnd_sh_d[k];
            bit_cnt_q    <= bit_cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (adder_rdy) begin
            sum_data_q  <= adder_result;
            sum_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end
`ifdef PAC_TIMEOUT_EN
          else if (wait_cnt_q == WAIT_LAST) begin
            err_q       <= 1'b1;
            sum_data_q  <= '1;
            sum_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        S_HOLD: begin
          if (sum_ready) begin
            sum_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_LOAD;
          end
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign adder_clr  = adder_clr_q;
  assign adder_bits = adder_bits_q;
  assign sum_valid  = sum_valid_q;
  assign sum_data   = sum_data_q;
  assign busy       = busy_q;
`ifdef PAC_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_parallel_adder_stream_ctrl.sv
// tb/tb_parallel_adder_stream_ctrl.sv - bench for parallel_adder_stream_ctrl with a behavioural adder
// Watchdog checks compiled in when PAC_TIMEOUT_EN is defined.
module tb_parallel_adder_stream_ctrl;

  localparam int M  = 32;
  localparam int N  = 32;
  localparam int RW = 37;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic [RW-1:0] adder_result = '0;
  logic          adder_rdy = 1'b0;
  logic          sum_ready = 1'b0;
  logic          in_ready;
  logic          adder_clr;
  logic [M-1:0]  adder_bits;
  logic          sum_valid;
  logic [RW-1:0] sum_data;
  logic          busy;
  logic          err;

  parallel_adder_stream_ctrl #(.M(M), .N(N), .RW(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .adder_clr(adder_clr), .adder_bits(adder_bits),
    .adder_result(adder_result), .adder_rdy(adder_rdy),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural adder and reference state
  int            scnt = N;
  int            rdy_wait = -1;
  int            lat = 0;
  bit            rdy_block = 1'b0;
  logic [RW-1:0] acc = '0;
  logic [N-1:0]  ops [M];
  logic [RW-1:0] exp_sum = '0;
  logic [M-1:0]  slice0_seen = '0;
  logic          exp_err = 1'b0;

  typedef struct {
    int            pat;
    int            gap;
    int            stall;
    bit            has_exp;
    logic [RW-1:0] sum;
    bit            has_s0;
    logic [M-1:0]  s0;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic model_idle();
    scnt = N;
    rdy_wait = -1;
    adder_rdy = 1'b0;
  endtask

  // One clock: sample 1 time unit after the edge, advance the adder model, drive its outputs.
  task automatic tick();
    logic [M-1:0] e;
    @(posedge clk);
    #1;
    if (adder_clr) begin
      chk("clr_outside_stream", 64'(scnt > 0 && scnt < N), 64'd0);
      chk("bits_zero_in_clear", 64'(adder_bits), 64'd0);
      scnt = 0;
      acc = '0;
      rdy_wait = -1;
    end else if (scnt < N) begin
      e = '0;
      for (int k = 0; k < M; k++) e[M-1-k] = ops[k][scnt];
      chk($sformatf("slice_%0d", scnt), 64'(adder_bits), 64'(e));
      if (scnt == 0) slice0_seen = adder_bits;
      acc = acc + (RW'($countones(adder_bits)) << scnt);
      scnt++;
      if (scnt == N) rdy_wait = lat;
    end else begin
      chk("bits_zero_idle", 64'(adder_bits), 64'd0);
      if (rdy_wait > 0) rdy_wait--;
    end
    adder_rdy = (scnt == N && rdy_wait == 0 && !rdy_block);
    adder_result = adder_rdy ? acc : RW'({$urandom, $urandom});
  endtask

  task automatic load_ops(input int pat, input int gap);
    int  k;
    int  ph;
    int  guard;
    bit  v;
    bit  taken;
    exp_sum = '0;
    for (int i = 0; i < M; i++) begin
      case (pat)
        0:       ops[i] = 32'd100000000;
        1:       ops[i] = 32'hFFFF_FFFF;
        2:       ops[i] = N'(i);
        default: ops[i] = $urandom;
      endcase
      exp_sum = exp_sum + RW'(ops[i]);
    end
    lat = $urandom_range(0, 6);
    k = 0;
    ph = 0;
    guard = 0;
    while (k < M && guard < 4 * M + 10) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? (ph % 2 == 0) : 1'($urandom_range(0, 1));
      ph++;
      in_valid = v;
      in_data = v ? ops[k] : $urandom;
      taken = v && in_ready;
      tick();
      guard++;
      if (taken) k++;
    end
    in_valid = 1'b0;
    chk("load_accepts", 64'(k), 64'(M));
    chk("clear_pulse", 64'(adder_clr), 64'd1);
    chk("clear_in_ready", 64'(in_ready), 64'd0);
    chk("clear_busy", 64'(busy), 64'd1);
  endtask

  task automatic finish_sum(input int stall, input logic [RW-1:0] req);
    int            guard;
    bit            bad;
    logic [RW-1:0] held;
    sum_ready = 1'b0;
    guard = 0;
    bad = 1'b0;
    while (!sum_valid && guard < N + TO + 50) begin
      tick();
      guard++;
      if (in_ready || !busy) bad = 1'b1;
    end
    chk("busy_no_ready_before_sum", 64'(bad), 64'd0);
    chk("sum_valid_seen", 64'(sum_valid), 64'd1);
    chk("sum_data", 64'(sum_data), 64'(req));
    chk("err_at_sum", 64'(err), 64'(exp_err));
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    held = sum_data;
    bad = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (!sum_valid || sum_data !== held || in_ready || !busy) bad = 1'b1;
    end
    if (stall > 0) chk("hold_stable", 64'(bad), 64'd0);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    chk("after_accept_valid", 64'(sum_valid), 64'd0);
    chk("after_accept_in_ready", 64'(in_ready), 64'd1);
    chk("after_accept_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_sum_valid"}, 64'(sum_valid), 64'd0);
    chk({tag, "_sum_data"}, 64'(sum_data), 64'd0);
    chk({tag, "_adder_clr"}, 64'(adder_clr), 64'd0);
    chk({tag, "_adder_bits"}, 64'(adder_bits), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=expired required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int  guard;
    int  wcnt;
    bit  bad;

    tbl[0] = '{pat: 0, gap: 0, stall: 0,  has_exp: 1, sum: 37'h0_BEBC_2000, has_s0: 1, s0: 32'h0};
    tbl[1] = '{pat: 1, gap: 0, stall: 0,  has_exp: 1, sum: 37'h1F_FFFF_FFE0, has_s0: 1, s0: 32'hFFFF_FFFF};
    tbl[2] = '{pat: 2, gap: 1, stall: 0,  has_exp: 1, sum: 37'd496,          has_s0: 1, s0: 32'h5555_5555};
    tbl[3] = '{pat: 3, gap: 0, stall: 20, has_exp: 0, sum: '0,               has_s0: 0, s0: '0};
    tbl[4] = '{pat: 3, gap: 2, stall: 0,  has_exp: 0, sum: '0,               has_s0: 0, s0: '0};
    tbl[5] = '{pat: 3, gap: 2, stall: 3,  has_exp: 0, sum: '0,               has_s0: 0, s0: '0};

    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    chk("post_reset_busy", 64'(busy), 64'd0);

    for (int r = 0; r < 6; r++) begin
      load_ops(tbl[r].pat, tbl[r].gap);
      finish_sum(tbl[r].stall, tbl[r].has_exp ? tbl[r].sum : exp_sum);
      if (tbl[r].has_s0) chk($sformatf("row%0d_slice0", r), 64'(slice0_seen), 64'(tbl[r].s0));
    end

    // Reset in STREAM cycle 10 discards the operation; a fresh load must still sum correctly.
    load_ops(3, 0);
    guard = 0;
    while (scnt < 10 && guard < 40) begin
      tick();
      guard++;
    end
    tick();
    chk("mid_stream_cycle", 64'(scnt), 64'd11);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_idle();
    tick();
    chk("midrst_in_ready_held", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("midrst_release_in_ready", 64'(in_ready), 64'd1);
    load_ops(3, 2);
    finish_sum(0, exp_sum);

`ifdef PAC_TIMEOUT_EN
    rdy_block = 1'b1;
    load_ops(3, 0);
    guard = 0;
    while (scnt < N && guard < N + 10) begin
      tick();
      guard++;
    end
    wcnt = 0;
    while (!sum_valid && wcnt < TO + 10) begin
      tick();
      if (!sum_valid) wcnt++;
    end
    chk("wd_wait_cycles", 64'(wcnt), 64'(TO));
    chk("wd_err", 64'(err), 64'd1);
    exp_err = 1'b1;
    rdy_block = 1'b0;
    finish_sum(0, {RW{1'b1}});
    load_ops(3, 0);
    finish_sum(0, exp_sum);
    #1 rst_n = 1'b0;
    #1;
    chk("wd_err_cleared", 64'(err), 64'd0);
    exp_err = 1'b0;
    model_idle();
    tick();
    rst_n = 1'b1;
    tick();
    load_ops(3, 0);
    finish_sum(0, exp_sum);
`else
    rdy_block = 1'b1;
    load_ops(3, 0);
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (sum_valid || err) bad = 1'b1;
    end
    chk("no_watchdog_waits", 64'(bad), 64'd0);
    rdy_block = 1'b0;
    finish_sum(0, exp_sum);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
